// File: rtl/rvc_pkg.sv
// Shared RV32 opcode, funct3 and RVC selector constants for the fetch aligner
// and the compressed-instruction expander.
package rvc_pkg;

  localparam logic [6:0] OP     = 7'b0110011,
                         OP_IMM = 7'b0010011,
                         LOAD   = 7'b0000011,
                         STORE  = 7'b0100011,
                         BRANCH = 7'b1100011,
                         JAL    = 7'b1101111,
                         JALR   = 7'b1100111,
                         LUI    = 7'b0110111,
                         SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_W   = 3'b010,
                         F3_XOR = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110,
                         F3_AND = 3'b111, F3_BEQ = 3'b000, F3_BNE = 3'b001;

  localparam logic [4:0] X_ZERO = 5'd0, X_RA = 5'd1, X_SP = 5'd2;

  localparam logic [1:0] Q0 = 2'b00, Q1 = 2'b01, Q2 = 2'b10;

  // Selectors are {quadrant, funct3} of the 16-bit encoding.
  localparam logic [4:0] C_ADDI4SPN = {Q0, 3'b000}, C_LW   = {Q0, 3'b010},
                         C_SW       = {Q0, 3'b110}, C_ADDI = {Q1, 3'b000},
                         C_JAL      = {Q1, 3'b001}, C_LI   = {Q1, 3'b010},
                         C_LUI      = {Q1, 3'b011}, C_MISC = {Q1, 3'b100},
                         C_J        = {Q1, 3'b101}, C_BEQZ = {Q1, 3'b110},
                         C_BNEZ     = {Q1, 3'b111}, C_SLLI = {Q2, 3'b000},
                         C_LWSP     = {Q2, 3'b010}, C_JR_ADD = {Q2, 3'b100},
                         C_SWSP     = {Q2, 3'b110};

  function automatic logic [4:0] creg(input logic [2:0] r);
    return {2'b01, r};
  endfunction

endpackage

// File: rtl/rvc_expand.sv
// Combinational RV32C (integer subset) to RV32I expander; reserved encodings
// raise o_illegal and pass the raw halfword through zero-extended.
module rvc_expand
  import rvc_pkg::*;
(
  input  logic [15:0] i_inst,
  output logic [31:0] o_inst,
  output logic        o_illegal
);

  logic [4:0]  w_rd, w_rs2, w_rdp, w_rs1p;
  logic [11:0] w_imm6, w_sp_imm;
  logic [20:1] w_j_imm;
  logic [12:1] w_b_imm;
  logic [31:0] w_exp;
  logic        w_ill;

  assign w_rd     = i_inst[11:7];
  assign w_rs2    = i_inst[6:2];
  assign w_rdp    = creg(i_inst[4:2]);
  assign w_rs1p   = creg(i_inst[9:7]);
  assign w_imm6   = {{7{i_inst[12]}}, i_inst[6:2]};
  assign w_sp_imm = {{3{i_inst[12]}}, i_inst[4:3], i_inst[5], i_inst[2], i_inst[6], 4'b0};
  assign w_j_imm  = {{9{i_inst[12]}}, i_inst[12], i_inst[8], i_inst[10:9], i_inst[6],
                     i_inst[7], i_inst[2], i_inst[11], i_inst[5:3]};
  assign w_b_imm  = {{4{i_inst[12]}}, i_inst[12], i_inst[6:5], i_inst[2],
                     i_inst[11:10], i_inst[4:3]};

  // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_exp = 32'h0;
    w_ill = 1'b0;
    case ({i_inst[1:0], i_inst[15:13]})
      C_ADDI4SPN: begin
        w_exp = {2'b00, i_inst[10:7], i_inst[12:11], i_inst[5], i_inst[6], 2'b00,
                 X_SP, F3_ADD, w_rdp, OP_IMM};
        w_ill = (i_inst[12:5] == 8'h0);
      end
      C_LW:   w_exp = {5'b0, i_inst[5], i_inst[12:10], i_inst[6], 2'b00, w_rs1p, F3_W, w_rdp, LOAD};
      C_SW:   w_exp = {5'b0, i_inst[5], i_inst[12], w_rdp, w_rs1p, F3_W,
                       i_inst[11:10], i_inst[6], 2'b00, STORE};
      C_ADDI: w_exp = {w_imm6, w_rd, F3_ADD, w_rd, OP_IMM};
      C_JAL:  w_exp = {w_j_imm[20], w_j_imm[10:1], w_j_imm[11], w_j_imm[19:12], X_RA, JAL};
      C_LI:   w_exp = {w_imm6, X_ZERO, F3_ADD, w_rd, OP_IMM};
      C_LUI: begin
        w_ill = ({i_inst[12], i_inst[6:2]} == 6'h0);
        if (w_rd == X_SP) w_exp = {w_sp_imm, X_SP, F3_ADD, X_SP, OP_IMM};
        else              w_exp = {{15{i_inst[12]}}, i_inst[6:2], w_rd, LUI};
      end
      C_MISC: begin
        case (i_inst[11:10])
          2'b00: begin
            w_exp = {7'b0, i_inst[6:2], w_rs1p, F3_SR, w_rs1p, OP_IMM};
            w_ill = i_inst[12];
          end
          2'b01: begin
            w_exp = {7'b0100000, i_inst[6:2], w_rs1p, F3_SR, w_rs1p, OP_IMM};
            w_ill = i_inst[12];
          end
          2'b10: w_exp = {w_imm6, w_rs1p, F3_AND, w_rs1p, OP_IMM};
          default: begin
            w_ill = i_inst[12];
            case (i_inst[6:5])
              2'b00:   w_exp = {7'b0100000, w_rdp, w_rs1p, F3_ADD, w_rs1p, OP};
              2'b01:   w_exp = {7'b0, w_rdp, w_rs1p, F3_XOR, w_rs1p, OP};
              2'b10:   w_exp = {7'b0, w_rdp, w_rs1p, F3_OR, w_rs1p, OP};
              default: w_exp = {7'b0, w_rdp, w_rs1p, F3_AND, w_rs1p, OP};
            endcase
          end
        endcase
      end
      C_J:    w_exp = {w_j_imm[20], w_j_imm[10:1], w_j_imm[11], w_j_imm[19:12], X_ZERO, JAL};
      C_BEQZ: w_exp = {w_b_imm[12], w_b_imm[10:5], X_ZERO, w_rs1p, F3_BEQ,
                       w_b_imm[4:1], w_b_imm[11], BRANCH};
      C_BNEZ: w_exp = {w_b_imm[12], w_b_imm[10:5], X_ZERO, w_rs1p, F3_BNE,
                       w_b_imm[4:1], w_b_imm[11], BRANCH};
      C_SLLI: begin
        w_exp = {7'b0, i_inst[6:2], w_rd, F3_SLL, w_rd, OP_IMM};
        w_ill = i_inst[12];
      end
      C_LWSP: begin
        w_exp = {4'b0, i_inst[3:2], i_inst[12], i_inst[6:4], 2'b00, X_SP, F3_W, w_rd, LOAD};
        w_ill = (w_rd == X_ZERO);
      end
      C_SWSP: w_exp = {4'b0, i_inst[8:7], i_inst[12], w_rs2, X_SP, F3_W,
                       i_inst[11:9], 2'b00, STORE};
      C_JR_ADD: begin
        if (!i_inst[12]) begin
          if (w_rs2 == X_ZERO) begin
            w_exp = {12'h0, w_rd, F3_ADD, X_ZERO, JALR};
            w_ill = (w_rd == X_ZERO);
          end else begin
            w_exp = {7'b0, w_rs2, X_ZERO, F3_ADD, w_rd, OP};
          end
        end else if (w_rs2 == X_ZERO) begin
          if (w_rd == X_ZERO) w_exp = {12'h001, X_ZERO, 3'b000, X_ZERO, SYSTEM};
          else                w_exp = {12'h0, w_rd, F3_ADD, X_RA, JALR};
        end else begin
          w_exp = {7'b0, w_rs2, w_rd, F3_ADD, w_rd, OP};
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign o_illegal = w_ill;
  assign o_inst    = w_ill ? {16'h0, i_inst} : w_exp;

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Halfword ring buffer between instruction memory and decode: realigns 16/32-bit
// instructions (including word-straddling ones) and expands RVC encodings.
module rvc_fetch_aligner
  import rvc_pkg::*;
#(
  parameter int unsigned DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_valid,
  output logic                        fetch_ready,
  input  logic [31:0]                 fetch_data,
  input  logic                        flush,
  input  logic [31:0]                 flush_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_inst,
  output logic [31:0]                 out_pc,
  output logic                        out_is_c,
  output logic                        out_illegal,
  output logic [$clog2(DEPTH_HW):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH_HW);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(DEPTH_HW - 2);

  logic [15:0]      r_buf [DEPTH_HW];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pc;
  logic             r_drop_low;

  logic [PTR_W-1:0] w_rd_ptr1, w_wr_ptr1;
  logic [15:0]      w_hw0, w_hw1;
  logic [31:0]      w_exp;
  logic             w_exp_ill, w_is_c, w_push, w_pop, w_unused;
  logic [CNT_W-1:0] w_push_n, w_pop_n;

  assign w_unused  = flush_pc[0];
  assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);
  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
  assign w_hw0     = r_buf[r_rd_ptr];
  assign w_hw1     = r_buf[w_rd_ptr1];
  assign w_is_c    = (w_hw0[1:0] != 2'b11);

  rvc_expand u_expand (
    .i_inst    (w_hw0),
    .o_inst    (w_exp),
    .o_illegal (w_exp_ill)
  );

  // Handshake outputs depend only on registered state, never on the partner's valid/ready.
  assign fetch_ready = (r_count <= FULL_LIM);
  assign out_valid   = w_is_c ? (r_count != '0) : (r_count >= CNT_W'(2));
  assign out_inst    = w_is_c ? w_exp : {w_hw1, w_hw0};
  assign out_pc      = r_pc;
  assign out_is_c    = w_is_c;
  assign out_illegal = w_is_c & w_exp_ill;
  assign occupancy   = r_count;

  assign w_push   = fetch_valid & fetch_ready & ~flush & ~rst;
  assign w_pop    = out_valid & out_ready & ~flush & ~rst;
  assign w_push_n = w_push ? (r_drop_low ? CNT_W'(1) : CNT_W'(2)) : '0;
  assign w_pop_n  = w_pop ? (w_is_c ? CNT_W'(1) : CNT_W'(2)) : '0;

  // NOTE: the halfword array has no reset; count and pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      if (r_drop_low) begin
        r_buf[r_wr_ptr] <= fetch_data[31:16];
      end else begin
        r_buf[r_wr_ptr]  <= fetch_data[15:0];
        r_buf[w_wr_ptr1] <= fetch_data[31:16];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pc       <= rst ? {RESET_PC[31:1], 1'b0} : {flush_pc[31:1], 1'b0};
      r_drop_low <= rst ? RESET_PC[1] : flush_pc[1];
    end else begin
      r_rd_ptr <= r_rd_ptr + w_pop_n[PTR_W-1:0];
      r_wr_ptr <= r_wr_ptr + w_push_n[PTR_W-1:0];
      r_count  <= r_count + w_push_n - w_pop_n;
      r_pc     <= r_pc + 32'({w_pop_n, 1'b0});
      if (w_push) r_drop_low <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Scoreboard bench for rvc_fetch_aligner: expected instructions are queued as
// words are driven and compared whenever decode accepts one.
module tb_rvc_fetch_aligner;

  localparam int DEPTH = 8;
  localparam logic [31:0] RST_PC = 32'h0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, fetch_valid, fetch_ready, flush, out_valid, out_ready;
  logic        out_is_c, out_illegal;
  logic [31:0] fetch_data, flush_pc, out_inst, out_pc;
  logic [3:0]  occupancy;

  exp_t        sb[$];
  logic [31:0] m_pc;
  int          n_vec = 0;
  int          n_err = 0;

  localparam int N_TAB = 18;
  logic [15:0] tab_hw  [N_TAB] = '{16'h0800, 16'h41C8, 16'hC588, 16'h157D, 16'hBFFD, 16'hC501,
                                   16'h050E, 16'h4532, 16'hC22A, 16'h852E, 16'h952E, 16'h8082,
                                   16'h9002, 16'h8C05, 16'h6505, 16'h4002, 16'h6101, 16'h0001};
  logic [31:0] tab_exp [N_TAB] = '{32'h01010413, 32'h0045A503, 32'h00A5A423, 32'hFFF50513,
                                   32'hFFFFF06F, 32'h00050463, 32'h00351513, 32'h00C12503,
                                   32'h00A12223, 32'h00B00533, 32'h00B50533, 32'h00008067,
                                   32'h00100073, 32'h40940433, 32'h00001537, 32'h00004002,
                                   32'h00006101, 32'h00000013};
  logic        tab_ill [N_TAB] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

  rvc_fetch_aligner #(.DEPTH_HW(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_is_c    (out_is_c),
    .out_illegal (out_illegal),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] inst, input logic is_c, input logic ill);
    sb.push_back('{inst: inst, pc: m_pc, is_c: is_c, ill: ill});
    m_pc = m_pc + (is_c ? 32'd2 : 32'd4);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    fetch_valid = 1'b1;
    fetch_data  = w;
    while (!fetch_ready && n < 100) begin
      tick();
      n++;
    end
    if (!fetch_ready) check("fetch_ready_timeout", 32'(fetch_ready), 32'h1);
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic drain(input int keep);
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() > keep && n < 100) begin
      tick();
      n++;
    end
    if (sb.size() > keep) check("drain_timeout", 32'(sb.size()), 32'(keep));
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("inst", out_inst, e.inst);
        check("pc", out_pc, e.pc);
        check("is_c", 32'(out_is_c), 32'(e.is_c));
        check("illegal", 32'(out_illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_data = '0; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    m_pc = {RST_PC[31:1], 1'b0};
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'h1);
    check("rst_occupancy", 32'(occupancy), 32'h0);
    check("rst_out_pc", out_pc, {RST_PC[31:1], 1'b0});

    // Aligned 32-bit instruction, valid the cycle after acceptance.
    exp_push(32'h00A00513, 1'b0, 1'b0);
    send_word(32'h00A00513);
    check("w32_out_valid", 32'(out_valid), 32'h1);
    check("w32_occupancy", 32'(occupancy), 32'h2);
    drain(0);
    check("w32_occ_after", 32'(occupancy), 32'h0);
    check("w32_valid_after", 32'(out_valid), 32'h0);

    // Two compressed instructions in one word.
    exp_push(32'h00000513, 1'b1, 1'b0);
    exp_push(32'h00A00513, 1'b1, 1'b0);
    send_word(32'h45294501);
    check("cc_occupancy", 32'(occupancy), 32'h2);
    drain(0);

    // 32-bit instruction straddling a word boundary.
    exp_push(32'h00000013, 1'b1, 1'b0);
    exp_push(32'h00A00513, 1'b0, 1'b0);
    send_word(32'h05130001);
    drain(1);
    check("strad_lone_valid", 32'(out_valid), 32'h0);
    check("strad_lone_occ", 32'(occupancy), 32'h1);
    send_word(32'h000000A0);
    check("strad_valid", 32'(out_valid), 32'h1);
    check("strad_is_c", 32'(out_is_c), 32'h0);
    drain(0);
    check("strad_occ_after", 32'(occupancy), 32'h1);

    // Fill, then flush with both handshakes asserted in the flush cycle.
    repeat (3) send_word(32'h00010001);
    check("full_fetch_ready", 32'(fetch_ready), 32'h0);
    check("full_occupancy", 32'(occupancy), 32'h7);
    flush = 1'b1; flush_pc = 32'h102; fetch_valid = 1'b1; fetch_data = 32'hFFFFFFFF; out_ready = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0; out_ready = 1'b0;
    m_pc = 32'h102;
    check("flush_out_valid", 32'(out_valid), 32'h0);
    check("flush_occupancy", 32'(occupancy), 32'h0);
    check("flush_out_pc", out_pc, 32'h102);
    check("flush_fetch_ready", 32'(fetch_ready), 32'h1);
    exp_push(32'h00A00513, 1'b1, 1'b0);
    send_word(32'h45294501);
    check("droplow_occupancy", 32'(occupancy), 32'h1);
    drain(0);
    check("droplow_occ_after", 32'(occupancy), 32'h0);

    // Backpressure with reserved all-zero halfwords.
    flush = 1'b1; flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    m_pc = 32'h200;
    for (int k = 1; k <= DEPTH / 2; k++) begin
      send_word(32'h0);
      check("bp_occupancy", 32'(occupancy), 32'(2 * k));
      check("bp_fetch_ready", 32'(fetch_ready), 32'((2 * k) <= DEPTH - 2));
    end
    check("ill_out_valid", 32'(out_valid), 32'h1);
    check("ill_flag", 32'(out_illegal), 32'h1);
    check("ill_inst", out_inst, 32'h0);
    check("ill_is_c", 32'(out_is_c), 32'h1);
    repeat (2) tick();
    check("hold_inst", out_inst, 32'h0);
    check("hold_pc", out_pc, 32'h200);
    check("hold_valid", 32'(out_valid), 32'h1);
    repeat (DEPTH) exp_push(32'h0, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick();
    check("pop1_occupancy", 32'(occupancy), 32'h7);
    check("pop1_fetch_ready", 32'(fetch_ready), 32'h0);
    tick();
    check("pop2_occupancy", 32'(occupancy), 32'h6);
    check("pop2_fetch_ready", 32'(fetch_ready), 32'h1);
    drain(0);

    // Expansion table streamed with decode always ready.
    for (int i = 0; i < N_TAB; i++) exp_push(tab_exp[i], 1'b1, tab_ill[i]);
    out_ready = 1'b1;
    for (int w = 0; w < N_TAB / 2; w++) send_word({tab_hw[2 * w + 1], tab_hw[2 * w]});
    drain(0);
    check("stream_occ_after", 32'(occupancy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvc_fetch_aligner.md
# rvc_fetch_aligner

Parametrised fetch-side front end for the RV32IC core. It accepts sequential 32-bit instruction-memory words and buffers them as halfwords. It realigns 16/32-bit instructions, including 32-bit instructions that straddle a word boundary, and expands RV32C encodings to their 32-bit equivalents. It sits between instruction memory and the IF/ID pipeline register, and hands decode one aligned 32-bit instruction per cycle with its PC over a valid/ready handshake.

## Interface
- `DEPTH_HW`, 8: halfword buffer depth; power of two, ≥4.
- `RESET_PC`, 32'h0: PC of the first instruction after reset; bit 1 selects the starting halfword, bit 0 ignored.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `fetch_valid` in 1: `fetch_data` holds the next sequential memory word.
- `fetch_ready` out 1: buffer can take a word this cycle.
- `fetch_data` in 32: little-endian word; [15:0] is the lower-address halfword.
- `flush` in 1: redirect (branch/jump/trap).
- `flush_pc` in 32: redirect target; bit 0 ignored.
- `out_valid` out 1: a complete instruction is at the buffer head.
- `out_ready` in 1: decode consumes the head instruction.
- `out_inst` out 32: expanded instruction.
- `out_pc` out 32: address of the head instruction.
- `out_is_c` out 1: head instruction was 16-bit; the PC advances by 2.
- `out_illegal` out 1: reserved/illegal compressed encoding.
- `occupancy` out $clog2(DEPTH_HW)+1: halfwords currently buffered.

## Operation
- State: circular halfword array, `rd_ptr`, `wr_ptr` (wrap modulo `DEPTH_HW`), `count`, `pc`, and `drop_low` (the next word's lower halfword is skipped).
- Fetch accept: `fetch_valid && fetch_ready`, with `fetch_ready = (count <= DEPTH_HW-2)`.
  - Pushes [15:0] then [31:16].
  - If `drop_low` is set, pushes only [31:16] and clears `drop_low`.
- Head decode:
  - Head halfword [1:0] != 2'b11: 16-bit instruction, length 1. Valid if `count>=1`.
  - Otherwise: 32-bit instruction, length 2. Valid if `count>=2`; `out_inst = {hw[rd_ptr+1], hw[rd_ptr]}`.
- Expansion: full RV32C integer subset (C0/C1/C2 quadrants, no F/D).
  - Reserved encodings, including 16'h0000, c.addi4spn with nzuimm=0, and c.lui/c.addi16sp with imm=0, set `out_illegal=1` and `out_inst={16'h0,raw}`.
  - Hints expand normally.
- Pop on `out_valid && out_ready`: `rd_ptr += len`, `count -= len`, `pc += 2*len` (32-bit wrap).
- Simultaneous push and pop: `count_next = count + push_n − pop_n`. Never overflows, because `fetch_ready` is computed from registered `count`.
- Flush has highest priority.
  - Sets `count=0` and `rd_ptr=wr_ptr=0`.
  - Sets `pc={flush_pc[31:1],1'b0}` and `drop_low=flush_pc[1]`.
  - Any fetch or output handshake in the flush cycle is discarded with no effect.
- `rst` behaves like a flush to `RESET_PC` and overrides `flush`.

## Timing
- Reset values (cycle after `rst`):
  - `out_valid=0`, `fetch_ready=1`, `occupancy=0`.
  - `out_pc=RESET_PC` with bit 0 cleared.
  - `out_inst`, `out_is_c`, `out_illegal` reflect stale array contents and are don't-care while `out_valid=0`.
- Latency: a word accepted in cycle N can produce `out_valid` in cycle N+1. Outputs are combinational from registered state only; no `out_ready`→`out_valid` path and no `fetch_valid`→`fetch_ready` path.
- A straddling 32-bit instruction holds `out_valid=0` until its second halfword is accepted, then is valid the next cycle.
- Throughput: one instruction per cycle when not starved.
- Full buffer (`count>DEPTH_HW-2`): `fetch_ready=0`. A pop in that cycle does not raise `fetch_ready` until the next cycle.
- Empty (`count=0`): `out_valid=0`. A pending lone upper halfword of a 32-bit instruction also gives `out_valid=0`.
- `out_*` signals are stable while `out_valid && !out_ready`, absent flush.

## Structure
- Package `rvc_pkg`:
  - RV32 opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, SYSTEM).
  - RVC quadrant/funct3 constants.
  - Compressed register mapping helper (x8+rs').
- Sub-module `rvc_expand`: purely combinational, `[15:0]` in → `[31:0]` expanded plus `illegal` out. The aligner instantiates it on the head halfword.

## Test plan
- Reset: assert `rst` 2 cycles → `out_valid=0`, `fetch_ready=1`, `occupancy=0`, `out_pc=RESET_PC`.
- Word 32'h00A00513 → next cycle `out_inst=32'h00A00513`, `out_pc=0`, `out_is_c=0`; pop → `occupancy=0`.
- Word 32'h45294501 → `out_inst=32'h00000513` @pc 0, then `32'h00A00513` @pc 2, both with `out_is_c=1`.
- Straddle: word 32'h05130001 → `32'h00000013` @pc 0, then `out_valid=0`; word 32'h000000A0 → `32'h00A00513` @pc 2, `occupancy=1` after the pop.
- Flush to 32'h102 with buffer full and `out_ready=0` → next cycle `out_valid=0`, `occupancy=0`; word 32'h45294501 → `32'h00A00513` @pc 32'h102 only.
- Backpressure/illegal: hold `out_ready=0` and feed `DEPTH_HW/2` words → `fetch_ready=0` once `occupancy>DEPTH_HW-2`; head 16'h0000 → `out_illegal=1`, `out_inst=0`.
